// File: rtl/mem_word_master.sv
// mem_word_master: turns 32-bit word requests into four sequenced byte accesses on a byte-wide memory port
// and latches the memory's end-of-program flag as a sticky halt.
module mem_word_master #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req,
  input  logic             we,
  input  logic [WIDTH-1:0] addr,
  input  logic [31:0]      wdata,
  output logic             ready,
  output logic             done,
  output logic [31:0]      rdata,
  output logic             halt,
  output logic             memread,
  output logic             memwrite,
  output logic [WIDTH-1:0] mar,
  output logic [7:0]       writedata,
  input  logic [7:0]       memdata,
  input  logic             kraj
);
  typedef enum logic [1:0] {IDLE, RD, RDLAST, WR} state_t;
  state_t           state_q;
  logic [1:0]       k_q;
  logic [WIDTH-3:0] base_q;
  logic [31:0]      wdata_q, rdata_q;
  logic [WIDTH-1:0] mar_q;
  logic [7:0]       writedata_q;
  logic             done_q, halt_q, ready_q, memread_q, memwrite_q;
  logic             halt_d;
  logic             unused_addr_lsbs;
  assign unused_addr_lsbs = ^addr[1:0];
  assign halt_d = halt_q | kraj;
  // Read bytes arrive two edges after their address is driven, so byte k-2 lands as k advances.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      k_q         <= 2'd0;
      base_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      mar_q       <= '0;
      writedata_q <= '0;
      done_q      <= 1'b0;
      halt_q      <= 1'b0;
      ready_q     <= 1'b0;
      memread_q   <= 1'b0;
      memwrite_q  <= 1'b0;
    end else begin
      halt_q  <= halt_d;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req && ready_q) begin
            base_q <= addr[WIDTH-1:2];
            k_q    <= 2'd1;
            mar_q  <= {addr[WIDTH-1:2], 2'b00};
            if (we) begin
              state_q     <= WR;
              memwrite_q  <= 1'b1;
              wdata_q     <= wdata;
              writedata_q <= wdata[7:0];
            end else begin
              state_q   <= RD;
              memread_q <= 1'b1;
            end
          end else ready_q <= !halt_d;
        end
        RD: begin
          if (k_q != 2'd1) rdata_q[{k_q - 2'd2, 3'd0} +: 8] <= memdata;
          k_q <= k_q + 2'd1;
          if (k_q == 2'd0) begin
            memread_q <= 1'b0;
            state_q   <= RDLAST;
          end else mar_q <= {base_q, k_q};
        end
        RDLAST: begin
          rdata_q[31:24] <= memdata;
          done_q         <= 1'b1;
          state_q        <= IDLE;
          ready_q        <= !halt_d;
        end
        WR: begin
          k_q <= k_q + 2'd1;
          if (k_q == 2'd0) begin
            memwrite_q <= 1'b0;
            done_q     <= 1'b1;
            state_q    <= IDLE;
            ready_q    <= !halt_d;
          end else begin
            mar_q       <= {base_q, k_q};
            writedata_q <= wdata_q[{k_q, 3'd0} +: 8];
          end
        end
      endcase
    end
  end
  assign ready     = ready_q;
  assign done      = done_q;
  assign rdata     = rdata_q;
  assign halt      = halt_q;
  assign memread   = memread_q;
  assign memwrite  = memwrite_q;
  assign mar       = mar_q;
  assign writedata = writedata_q;
endmodule
